// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline definitions: datapath width, canonical NOP, the IF/ID
// payload record and the occupancy state of a pipeline boundary register.
package cpu_pipe_pkg;

  localparam int unsigned XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } if_id_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    FULL2 = 2'd2
  } occ_state_e;

  // Occupancy state from the two slot valid bits (skid only ever fills behind out).
  function automatic occ_state_e occ_state(input logic out_v, input logic skid_v);
    if (skid_v)     return FULL2;
    else if (out_v) return FULL;
    else            return EMPTY;
  endfunction

endpackage

// File: rtl/pipe_slot_reg.sv
// One pipeline slot: a valid bit plus a payload word, with load and clear.
// Clear takes priority over load; clear leaves the payload untouched.
module pipe_slot_reg #(
  parameter int unsigned  W       = 64,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] data_in,
  output logic         valid,
  output logic [W-1:0] data_out
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  // Next-state: clear empties the slot, load captures a new payload.
  always_comb begin
    // NOTE: every signal gets a default before the conditions, so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = data_in;
    end
  end

  // Slot state register.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: the payload is reset as well as valid, because its reset value is observable on the outputs.
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= RST_VAL;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid    = valid_q;
  assign data_out = data_q;

endmodule

// File: rtl/if_id_stage_pipe.sv
// IF/ID pipeline boundary register with valid/ready handshake and flush.
// Carries {pc, instr} from fetch to decode; out_instr reads NOP while empty.
// Build option IF_ID_SKID_EN: adds a skid slot so in_ready comes from a flop
// instead of combinationally from out_ready (two entries of buffering).
module if_id_stage_pipe
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned        PC_W      = XLEN,
  parameter int unsigned        INSTR_W   = XLEN,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(cpu_pipe_pkg::NOP_INSTR),
  parameter logic [PC_W-1:0]    RESET_PC  = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy
);

  localparam int unsigned W = PC_W + INSTR_W;

  logic         accept, consume;
  occ_state_e   cur_state;
  logic [W-1:0] in_payload;
  logic         out_load, out_clear, out_valid_q;
  logic [W-1:0] out_d, out_q;
  logic         skid_valid_q;

`ifdef IF_ID_SKID_EN
  logic         skid_load, skid_clear, skid_valid_d;
  logic [W-1:0] skid_q;
  logic         in_ready_d, in_ready_q;
`endif

  // Handshake decode and per-slot load/clear; flush overrides everything.
  always_comb begin
    in_payload = {in_pc, in_instr};
    accept     = in_valid & in_ready;
    consume    = out_valid_q & out_ready;
    cur_state  = occ_state(out_valid_q, skid_valid_q);
    out_load   = 1'b0;
    out_clear  = 1'b0;
    out_d      = in_payload;
`ifdef IF_ID_SKID_EN
    skid_load  = 1'b0;
    skid_clear = 1'b0;
`endif
    if (flush) begin
      // A consume on the same edge has already happened downstream; clearing covers it once.
      out_clear = 1'b1;
`ifdef IF_ID_SKID_EN
      skid_clear = 1'b1;
`endif
    end else begin
      case (cur_state)
        EMPTY: out_load = accept;
        FULL: begin
          if (accept && consume) begin
            out_load = 1'b1;
`ifdef IF_ID_SKID_EN
          end else if (accept) begin
            skid_load = 1'b1;
`endif
          end else if (consume) begin
            out_clear = 1'b1;
          end
        end
        FULL2: begin
`ifdef IF_ID_SKID_EN
          // Never accepts here; a consume promotes the skid entry.
          if (consume) begin
            out_load   = 1'b1;
            out_d      = skid_q;
            skid_clear = 1'b1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

  pipe_slot_reg #(
    .W       (W),
    .RST_VAL ({RESET_PC, NOP_INSTR})
  ) u_out_slot (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (out_load),
    .clear    (out_clear),
    .data_in  (out_d),
    .valid    (out_valid_q),
    .data_out (out_q)
  );

`ifdef IF_ID_SKID_EN
  pipe_slot_reg #(
    .W       (W),
    .RST_VAL ({RESET_PC, NOP_INSTR})
  ) u_skid_slot (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (skid_load),
    .clear    (skid_clear),
    .data_in  (in_payload),
    .valid    (skid_valid_q),
    .data_out (skid_q)
  );

  // Registered ready: next cycle accepts exactly when the skid slot will be empty.
  always_comb begin
    skid_valid_d = skid_valid_q;
    if (skid_clear)     skid_valid_d = 1'b0;
    else if (skid_load) skid_valid_d = 1'b1;
    in_ready_d = ~skid_valid_d;
  end

  // in_ready flop; low in reset, high from the first edge after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) in_ready_q <= 1'b0;
    else          in_ready_q <= in_ready_d;
  end

  assign in_ready = in_ready_q;
`else
  logic alive_d, alive_q;

  assign skid_valid_q = 1'b0;

  // Out-of-reset marker so in_ready stays low until the first edge after release.
  always_comb begin
    alive_d = 1'b1;
  end

  // Out-of-reset flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) alive_q <= 1'b0;
    else          alive_q <= alive_d;
  end

  assign in_ready = alive_q & (~out_valid_q | out_ready);
`endif

  assign out_valid = out_valid_q;
  assign out_pc    = out_q[W-1:INSTR_W];
  assign out_instr = out_valid_q ? out_q[INSTR_W-1:0] : NOP_INSTR;
  assign occupancy = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_if_id_stage_pipe.sv
// Scoreboard bench for if_id_stage_pipe. The reference is a FIFO of accepted
// entries: accepts append, consumes pop the head, flush empties it. Works with
// or without IF_ID_SKID_EN (capacity 2 or 1).
module tb_if_id_stage_pipe;
  import cpu_pipe_pkg::*;

`ifdef IF_ID_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [1:0]  occupancy;

  if_id_stage_pipe dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int     n_vec = 0;
  int     n_err = 0;
  logic   mon_en = 1'b0;
  logic   live = 1'b0;
  logic   pend_acc = 1'b0;
  if_id_t pend_entry;
  if_id_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decode may only be fed once the stage has seen a clock edge out of reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) live = 1'b0;
    else          live = 1'b1;
  end

  // Monitor: compare presented outputs against the model FIFO, then retire.
  always @(negedge clk) begin
    if (reset_n && mon_en) begin
      if (sb.size() > 0) begin
        check("out_valid", out_valid, 1'b1);
        check("out_pc", out_pc, sb[0].pc);
        check("out_instr", out_instr, sb[0].instr);
      end else begin
        check("out_valid", out_valid, 1'b0);
        check("nop_instr", out_instr, NOP_INSTR);
      end
      check("occupancy", occupancy, sb.size());
      check("in_ready", in_ready,
            live && ((sb.size() < CAP) || (CAP == 1 && out_ready)));
      if (sb.size() > 0 && out_ready) void'(sb.pop_front());
      if (flush) sb.delete();
    end
  end

  // One clock of stimulus; the accept seen before the edge is booked after it.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    if (pend_acc) sb.push_back(pend_entry);
    pend_acc  = 1'b0;
    in_valid  = v;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    if (v && in_ready && !fl) begin
      pend_acc   = 1'b1;
      pend_entry = '{pc: pc, instr: ins};
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_instr", out_instr, 32'h13);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_occupancy", occupancy, 2'd0);
    sb.delete();
    pend_acc  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pc;
    int          n_acc;
    int          guard;

    // Power-on reset
    #2;
    check("por_out_valid", out_valid, 1'b0);
    check("por_in_ready", in_ready, 1'b0);
    @(negedge clk);
    @(negedge clk);
    #1 reset_n = 1'b1;
    mon_en = 1'b1;

    // Stream at full rate
    cycle(1'b1, 32'h100, 32'hA000_0100, 1'b1, 1'b0);
    cycle(1'b1, 32'h104, 32'hA000_0104, 1'b1, 1'b0);
    check("stream_pc0", out_pc, 32'h100);
    cycle(1'b1, 32'h108, 32'hA000_0108, 1'b1, 1'b0);
    check("stream_pc1", out_pc, 32'h104);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("stream_pc2", out_pc, 32'h108);
    drain(2);

    // Stall four cycles with fetch pushing
    pc = 32'h100;
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, pc, 32'hB000_0000 | pc, 1'b0, 1'b0);
      if (pend_acc) begin
        n_acc++;
        pc += 4;
      end
    end
    check("stall_accepts", n_acc, CAP);
    check("stall_out_pc", out_pc, 32'h100);
    check("stall_in_ready", in_ready, 1'b0);
    guard = 0;
    while (pc <= 32'h108 && guard < 20) begin
      cycle(1'b1, pc, 32'hB000_0000 | pc, 1'b1, 1'b0);
      if (pend_acc) pc += 4;
      guard++;
    end
    check("release_done", pc, 32'h10C);
    drain(3);

    // Flush while full with fetch still valid
    pc = 32'h300;
    guard = 0;
    while (guard < 8 && !(pend_acc && occupancy == 2'(CAP - 1))) begin
      cycle(1'b1, pc, 32'hC000_0000 | pc, 1'b0, 1'b0);
      if (pend_acc) pc += 4;
      guard++;
    end
    cycle(1'b1, 32'h3F0, 32'hC000_03F0, 1'b0, 1'b0);
    check("pre_flush_occ", occupancy, CAP);
    cycle(1'b1, 32'h3F4, 32'hC000_03F4, 1'b0, 1'b1);
    cycle(1'b1, 32'h200, 32'hD000_0200, 1'b1, 1'b0);
    check("flush_out_valid", out_valid, 1'b0);
    check("flush_out_instr", out_instr, 32'h13);
    check("flush_occupancy", occupancy, 2'd0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("post_flush_valid", out_valid, 1'b1);
    check("post_flush_pc", out_pc, 32'h200);
    drain(2);

    // Consume and flush on the same edge
    cycle(1'b1, 32'h100, 32'hE000_0100, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    check("cf_seen_pc", out_pc, 32'h100);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    check("cf_bubble", out_valid, 1'b0);

    // Reset in the middle of traffic
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 32'h400 + 32'(4 * i), $urandom, 1'($urandom_range(0, 1)), 1'b0);
    do_reset();

    // Randomised traffic
    for (int i = 0; i < 10000; i++) begin
      cycle(1'($urandom_range(0, 9) < 7), $urandom & 32'hFFFF_FFFC, $urandom,
            1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
    end
    drain(4);
    check("final_empty", occupancy, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
